// File: rtl/e_check_nxn.sv
// e_check_nxn: error-matrix checker. Consumes one matrix column per cycle
// and flags every element whose magnitude exceeds the tolerance. It reports
// the error count, row/column masks and the first-error coordinates.

module e_check_nxn #(
    parameter int          arraySize = 4,
    parameter int          zBits     = 8,
    parameter int unsigned tol       = 0
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         check_start,
    input  logic [zBits-1:0]                             e_0_in,
    input  logic [zBits-1:0]                             e_1_in,
    input  logic [zBits-1:0]                             e_2_in,
    input  logic [zBits-1:0]                             e_3_in,
    output logic                                         busy,
    output logic                                         done,
    output logic                                         err_flag,
    output logic [$clog2(arraySize*arraySize+1)-1:0]     err_count,
    output logic [$clog2(arraySize)-1:0]                 first_row,
    output logic [$clog2(arraySize)-1:0]                 first_col,
    output logic [arraySize-1:0]                         row_mask,
    output logic [arraySize-1:0]                         col_mask
);

    localparam int CW = $clog2(arraySize*arraySize+1);
    localparam int IW = $clog2(arraySize);
    localparam logic [zBits:0] TOL = (zBits+1)'(tol);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t                 r_state;
    state_t                 w_stateNext;
    logic [IW-1:0]          r_colCnt;

    logic [CW-1:0]          r_accCount;
    logic [arraySize-1:0]   r_accRowMask;
    logic [arraySize-1:0]   r_accColMask;
    logic                   r_accFound;
    logic [IW-1:0]          r_accFirstRow;
    logic [IW-1:0]          r_accFirstCol;

    logic [zBits-1:0]       w_rowData [arraySize];
    logic [zBits:0]         w_ext     [arraySize];
    logic [zBits:0]         w_mag     [arraySize];
    logic [arraySize-1:0]   w_flag;

    logic                   w_sample;
    logic                   w_lastCol;
    logic [IW-1:0]          w_colIdx;
    logic [CW-1:0]          w_countNext;
    logic [arraySize-1:0]   w_rowMaskNext;
    logic [arraySize-1:0]   w_colMaskNext;
    logic                   w_foundNext;
    logic [IW-1:0]          w_firstRowNext;
    logic [IW-1:0]          w_firstColNext;

    assign w_rowData[0] = e_0_in;
    assign w_rowData[1] = e_1_in;
    assign w_rowData[2] = e_2_in;
    assign w_rowData[3] = e_3_in;

    // Magnitude is formed one bit wider so the most negative value does not wrap
    for (genvar k = 0; k < arraySize; k++) begin : g_row
        assign w_ext[k]  = {w_rowData[k][zBits-1], w_rowData[k]};
        assign w_mag[k]  = w_ext[k][zBits] ? (~w_ext[k] + 1'b1) : w_ext[k];
        assign w_flag[k] = (w_mag[k] > TOL);
    end

    assign w_sample  = ((r_state == IDLE) && check_start) || (r_state == SCAN);
    assign w_lastCol = (r_state == SCAN) && (r_colCnt == IW'(arraySize-1));
    assign w_colIdx  = (r_state == SCAN) ? r_colCnt : '0;

    // Fold the current column into the accumulators; a new check starts from zero
    always_comb begin
        logic [CW-1:0]        baseCount;
        logic [arraySize-1:0] baseRowMask;
        logic [arraySize-1:0] baseColMask;
        logic                 baseFound;
        baseCount   = (r_state == SCAN) ? r_accCount    : '0;
        baseRowMask = (r_state == SCAN) ? r_accRowMask  : '0;
        baseColMask = (r_state == SCAN) ? r_accColMask  : '0;
        baseFound   = (r_state == SCAN) ? r_accFound    : 1'b0;
        w_firstRowNext = (r_state == SCAN) ? r_accFirstRow : '0;
        w_firstColNext = (r_state == SCAN) ? r_accFirstCol : '0;
        w_countNext = baseCount;
        for (int k = 0; k < arraySize; k++) begin
            w_countNext = w_countNext + CW'(w_flag[k]);
        end
        w_rowMaskNext = baseRowMask | w_flag;
        w_colMaskNext = baseColMask;
        if (|w_flag) begin
            w_colMaskNext[w_colIdx] = 1'b1;
        end
        w_foundNext = baseFound | (|w_flag);
        if (!baseFound && (|w_flag)) begin
            w_firstColNext = w_colIdx;
            for (int k = arraySize-1; k >= 0; k--) begin
                if (w_flag[k]) begin
                    w_firstRowNext = IW'(k);
                end
            end
        end
    end

    // Next-state decode: start on a pulse in IDLE, leave SCAN after the last column
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (check_start) w_stateNext = SCAN;
            SCAN:    if (w_lastCol)   w_stateNext = DONE;
            DONE:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Column counter and accumulators advance on every sampled column
    always_ff @(posedge clk) begin
        if (rst) begin
            r_colCnt      <= '0;
            r_accCount    <= '0;
            r_accRowMask  <= '0;
            r_accColMask  <= '0;
            r_accFound    <= 1'b0;
            r_accFirstRow <= '0;
            r_accFirstCol <= '0;
        end else if (w_sample) begin
            r_colCnt      <= (r_state == IDLE) ? IW'(1) : r_colCnt + 1'b1;
            r_accCount    <= w_countNext;
            r_accRowMask  <= w_rowMaskNext;
            r_accColMask  <= w_colMaskNext;
            r_accFound    <= w_foundNext;
            r_accFirstRow <= w_firstRowNext;
            r_accFirstCol <= w_firstColNext;
        end
    end

    // Registered outputs; results include the last column and hold until the next DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            err_flag  <= 1'b0;
            err_count <= '0;
            first_row <= '0;
            first_col <= '0;
            row_mask  <= '0;
            col_mask  <= '0;
        end else begin
            busy <= (w_stateNext != IDLE);
            done <= w_lastCol;
            if (w_lastCol) begin
                err_flag  <= w_foundNext;
                err_count <= w_countNext;
                first_row <= w_firstRowNext;
                first_col <= w_firstColNext;
                row_mask  <= w_rowMaskNext;
                col_mask  <= w_colMaskNext;
            end
        end
    end

endmodule

// File: tb/tb_e_check_nxn.sv
// Testbench for e_check_nxn: two instances (tol=0 and tol=4) share one input
// stream; directed table, hand-written corner sequences and random matrices.

module tb_e_check_nxn;

    typedef struct packed {
        logic [4:0] cnt;
        logic [1:0] fr;
        logic [1:0] fc;
        logic [3:0] rm;
        logic [3:0] cm;
    } res_t;

    typedef logic [15:0][7:0] mat_t;

    typedef struct packed {
        mat_t m;
        logic tolSel;
        res_t exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       checkStart;
    logic [7:0] e0, e1, e2, e3;

    logic       busy0, done0, flag0, busy4, done4, flag4;
    logic [4:0] cnt0, cnt4;
    logic [1:0] fr0, fc0, fr4, fc4;
    logic [3:0] rm0, cm0, rm4, cm4;
    res_t       act0, act4;
    res_t       prev0, prev4;

    int testsRun = 0;
    int testsFailed = 0;

    vec_t vecs [7];

    assign act0 = {cnt0, fr0, fc0, rm0, cm0};
    assign act4 = {cnt4, fr4, fc4, rm4, cm4};

    always #5 clk = ~clk;

    e_check_nxn #(.arraySize(4), .zBits(8), .tol(0)) dut0 (
        .clk(clk), .rst(rst), .check_start(checkStart),
        .e_0_in(e0), .e_1_in(e1), .e_2_in(e2), .e_3_in(e3),
        .busy(busy0), .done(done0), .err_flag(flag0), .err_count(cnt0),
        .first_row(fr0), .first_col(fc0), .row_mask(rm0), .col_mask(cm0)
    );

    e_check_nxn #(.arraySize(4), .zBits(8), .tol(4)) dut4 (
        .clk(clk), .rst(rst), .check_start(checkStart),
        .e_0_in(e0), .e_1_in(e1), .e_2_in(e2), .e_3_in(e3),
        .busy(busy4), .done(done4), .err_flag(flag4), .err_count(cnt4),
        .first_row(fr4), .first_col(fc4), .row_mask(rm4), .col_mask(cm4)
    );

    // Reference: scan column-major, count elements with |E| > t
    function automatic res_t model(input mat_t m, input int t);
        res_t r;
        bit   found;
        r = '0;
        found = 0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                int v;
                int mag;
                v = $signed(m[row*4+c]);
                mag = (v < 0) ? -v : v;
                if (mag > t) begin
                    r.cnt = r.cnt + 5'd1;
                    r.rm[row] = 1'b1;
                    r.cm[c] = 1'b1;
                    if (!found) begin
                        found = 1;
                        r.fr = 2'(row);
                        r.fc = 2'(c);
                    end
                end
            end
        end
        return r;
    endfunction

    function automatic vec_t mkVec(input logic tolSel, input int cnt, input int fr,
                                   input int fc, input logic [3:0] rm, input logic [3:0] cm);
        vec_t v;
        v = '0;
        v.tolSel = tolSel;
        v.exp.cnt = 5'(cnt);
        v.exp.fr = 2'(fr);
        v.exp.fc = 2'(fc);
        v.exp.rm = rm;
        v.exp.cm = cm;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic checkRes(input string tag, input res_t a, input logic af, input res_t e);
        checkOutput({tag, " err_count"}, int'(a.cnt), int'(e.cnt));
        checkOutput({tag, " first_row"}, int'(a.fr), int'(e.fr));
        checkOutput({tag, " first_col"}, int'(a.fc), int'(e.fc));
        checkOutput({tag, " row_mask"}, int'(a.rm), int'(e.rm));
        checkOutput({tag, " col_mask"}, int'(a.cm), int'(e.cm));
        checkOutput({tag, " err_flag"}, int'(af), int'(e.cnt != 0));
    endtask

    task automatic setCol(input mat_t m, input int c);
        e0 = m[0*4+c];
        e1 = m[1*4+c];
        e2 = m[2*4+c];
        e3 = m[3*4+c];
    endtask

    // Drives one full check from cycle 0; returns positioned in cycle 4
    task automatic applyStimulus(input mat_t m);
        checkStart = 1'b1;
        setCol(m, 0);
        tick();
        checkStart = 1'b0;
        for (int c = 1; c < 4; c++) begin
            setCol(m, c);
            checkOutput("busy0 in scan", int'(busy0), 1);
            checkOutput("busy4 in scan", int'(busy4), 1);
            checkOutput("done0 early", int'(done0), 0);
            checkRes("hold0", act0, flag0, prev0);
            checkRes("hold4", act4, flag4, prev4);
            tick();
        end
        checkOutput("busy0 at done", int'(busy0), 1);
        checkOutput("busy4 at done", int'(busy4), 1);
        checkOutput("done0 pulse", int'(done0), 1);
        checkOutput("done4 pulse", int'(done4), 1);
    endtask

    task automatic checkResults(input string tag, input res_t e0x, input res_t e4x);
        checkRes({tag, " tol0"}, act0, flag0, e0x);
        checkRes({tag, " tol4"}, act4, flag4, e4x);
        prev0 = e0x;
        prev4 = e4x;
    endtask

    task automatic checkIdleAfter(input string tag);
        tick();
        checkOutput({tag, " done0 cleared"}, int'(done0), 0);
        checkOutput({tag, " busy0 cleared"}, int'(busy0), 0);
        checkOutput({tag, " busy4 cleared"}, int'(busy4), 0);
    endtask

    initial begin
        mat_t mA;
        mat_t mB;
        mat_t mR;
        res_t e0x;
        res_t e4x;

        rst = 1'b1;
        checkStart = 1'b0;
        {e0, e1, e2, e3} = '0;
        prev0 = '0;
        prev4 = '0;

        // Directed table
        vecs[0] = mkVec(1'b0, 0, 0, 0, 4'b0000, 4'b0000);
        vecs[1] = mkVec(1'b0, 1, 2, 1, 4'b0100, 4'b0010);
        vecs[1].m[2*4+1] = 8'd5;
        vecs[2] = mkVec(1'b1, 2, 1, 2, 4'b1010, 4'b1100);
        vecs[2].m[0*4+0] = 8'd4;
        vecs[2].m[3*4+3] = 8'hFB;
        vecs[2].m[1*4+2] = 8'h80;
        vecs[3] = mkVec(1'b0, 2, 3, 0, 4'b1001, 4'b0101);
        vecs[3].m[3*4+0] = 8'd1;
        vecs[3].m[0*4+2] = 8'd1;
        vecs[4] = mkVec(1'b0, 16, 0, 0, 4'b1111, 4'b1111);
        vecs[4].m = {16{8'hFF}};
        vecs[5] = mkVec(1'b1, 16, 0, 0, 4'b1111, 4'b1111);
        vecs[5].m = {16{8'h80}};
        vecs[6] = mkVec(1'b1, 1, 0, 3, 4'b0001, 4'b1000);
        vecs[6].m[0*4+3] = 8'h7F;
        vecs[6].m[2*4+1] = 8'hFC;

        tick();
        tick();
        rst = 1'b0;
        checkRes("reset tol0", act0, flag0, '0);
        checkOutput("reset busy0", int'(busy0), 0);
        checkOutput("reset done0", int'(done0), 0);
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].m);
            if (vecs[i].tolSel) begin
                checkResults($sformatf("vec%0d", i), model(vecs[i].m, 0), vecs[i].exp);
            end else begin
                checkResults($sformatf("vec%0d", i), vecs[i].exp, model(vecs[i].m, 4));
            end
            checkIdleAfter($sformatf("vec%0d", i));
        end

        // Re-pulsed start in cycles 2 and 4 is ignored; cycle 5 starts a new check
        mA = vecs[1].m;
        mB = vecs[3].m;
        checkStart = 1'b1;
        setCol(mA, 0);
        tick();
        checkStart = 1'b0;
        setCol(mA, 1);
        tick();
        checkStart = 1'b1;
        setCol(mA, 2);
        tick();
        checkStart = 1'b0;
        setCol(mA, 3);
        tick();
        checkStart = 1'b1;
        checkOutput("repulse done0", int'(done0), 1);
        checkResults("repulse A", vecs[1].exp, model(mA, 4));
        tick();
        checkStart = 1'b0;
        checkOutput("repulse single done", int'(done0), 0);
        checkOutput("repulse idle busy", int'(busy0), 0);
        applyStimulus(mB);
        checkResults("repulse B", vecs[3].exp, model(mB, 4));
        checkIdleAfter("repulse B");

        // Reset in cycle 2 aborts a check with errors; start during reset ignored
        checkStart = 1'b1;
        setCol(vecs[4].m, 0);
        tick();
        checkStart = 1'b0;
        tick();
        rst = 1'b1;
        checkStart = 1'b1;
        tick();
        rst = 1'b0;
        checkStart = 1'b0;
        checkRes("abort tol0", act0, flag0, '0);
        checkRes("abort tol4", act4, flag4, '0);
        checkOutput("abort busy0", int'(busy0), 0);
        checkOutput("abort done0", int'(done0), 0);
        tick();
        checkOutput("abort no done0", int'(done0), 0);
        checkOutput("abort no done4", int'(done4), 0);
        checkOutput("abort busy stays low", int'(busy0), 0);
        tick();
        prev0 = '0;
        prev4 = '0;
        applyStimulus(vecs[2].m);
        checkResults("after abort", model(vecs[2].m, 0), vecs[2].exp);
        tick();

        // Random matrices, back to back at minimum spacing
        for (int n = 0; n < 40; n++) begin
            for (int k = 0; k < 16; k++) begin
                int r;
                r = int'($urandom_range(0, 9));
                if (r == 0) mR[k] = 8'h80;
                else if (r == 1) mR[k] = 8'h7F;
                else mR[k] = 8'(int'($urandom_range(0, 12)) - 6);
            end
            applyStimulus(mR);
            e0x = model(mR, 0);
            e4x = model(mR, 4);
            checkResults($sformatf("rand%0d", n), e0x, e4x);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
